// File: rtl/add_accumulator_pkg.sv
// Shared definitions for the burst accumulator: datapath width and FSM state encoding.
package add_accumulator_pkg;

  localparam int unsigned Width = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/add_accumulator_carry_select.sv
// 16-bit carry-select adder: 4-bit blocks precompute both carry-in cases, the ripple only muxes.
module add_accumulator_carry_select
  import add_accumulator_pkg::*;
(
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             carry_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned BlkW   = 4;
  localparam int unsigned NumBlk = Width / BlkW;

  logic [NumBlk:0] carry;

  assign carry[0] = carry_i;

  for (genvar i = 0; i < NumBlk; i++) begin : g_blk
    logic [BlkW:0] sum_c0;
    logic [BlkW:0] sum_c1;

    assign sum_c0 = {1'b0, a_i[i*BlkW +: BlkW]} + {1'b0, b_i[i*BlkW +: BlkW]};
    assign sum_c1 = {1'b0, a_i[i*BlkW +: BlkW]} + {1'b0, b_i[i*BlkW +: BlkW]}
                    + (BlkW + 1)'(1);

    assign sum_o[i*BlkW +: BlkW] = carry[i] ? sum_c1[BlkW-1:0] : sum_c0[BlkW-1:0];
    assign carry[i+1]            = carry[i] ? sum_c1[BlkW]     : sum_c0[BlkW];
  end

  assign carry_o = carry[NumBlk];

endmodule

// File: rtl/add_accumulator.sv
// Burst accumulator: sums a programmed number of streamed operands through the carry-select
// adder and presents the total plus a sticky wrap flag on a valid/ready result port.
module add_accumulator
  import add_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_flag,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  add_accumulator_carry_select u_adder (
    .a_i     (acc_q),
    .b_i     (in_data),
    .carry_i (1'b0),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    flag_d    = flag_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d  = '0;
          flag_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = StAccum;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAccum: begin
        if (in_valid) begin
          acc_d  = add_sum;
          flag_d = flag_q | add_carry;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // A start coinciding with this handshake is dropped: IDLE is only entered here.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum        = acc_q;
  assign carry_flag = flag_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator: directed scenarios plus randomized bursts
// compared against an arithmetic reference model.
module tb_add_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_flag;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] ops [256];

  add_accumulator #(
    .WIDTH (16),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .carry_flag (carry_flag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1;
    len   = 8'(l);
    tick();
    start = 1'b0;
  endtask

  // Drives ops[0..n-1] with random valid gaps; reports early out_valid or an expired budget.
  task automatic feed_ops(input int n, input int gap_pct, output bit early, output bit timeout);
    int  idx = 0;
    int  cyc = 0;
    bit  v;
    bit  rdy;
    early   = 1'b0;
    timeout = 1'b0;
    while (idx < n) begin
      if (cyc > n * 20 + 50) begin
        timeout = 1'b1;
        break;
      end
      v        = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = ops[idx];
      rdy      = in_ready;
      tick();
      if (v && rdy) idx++;
      if (idx < n && out_valid) early = 1'b1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic take_result(input int wait_cycles);
    out_ready = 1'b0;
    for (int i = 0; i < wait_cycles; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Reference: plain integer accumulation; a wrap is any partial sum reaching 2**16.
  task automatic model(input int n, output logic [15:0] exp_sum, output logic exp_flag);
    int unsigned s = 0;
    exp_flag = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + int'(ops[i]);
      if (s >= 65536) begin
        exp_flag = 1'b1;
        s = s - 65536;
      end
    end
    exp_sum = 16'(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({out_valid, in_ready, busy, carry_flag, sum} !== 20'h0)
      $display("FAIL reset_outputs: got ov=%b ir=%b busy=%b cf=%b sum=%h, want all 0",
               out_valid, in_ready, busy, carry_flag, sum);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit early, tmo;
    ops[0] = 16'd1; ops[1] = 16'd2; ops[2] = 16'd3;
    pulse_start(3);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_accum_state: got ir=%b busy=%b want 1 1", in_ready, busy);
    else n_pass++;
    feed_ops(3, 0, early, tmo);
    n_checks++;
    if (early || tmo || out_valid !== 1'b1)
      $display("FAIL basic_latency: got ov=%b early=%b tmo=%b want ov=1", out_valid, early, tmo);
    else n_pass++;
    n_checks++;
    if (sum !== 16'h0006 || carry_flag !== 1'b0)
      $display("FAIL basic_sum: got %h/%b want 0006/0", sum, carry_flag);
    else n_pass++;
    take_result(0);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_release: got ov=%b busy=%b want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_carry();
    bit early, tmo;
    ops[0] = 16'hFFFF; ops[1] = 16'h0002;
    pulse_start(2);
    feed_ops(2, 0, early, tmo);
    n_checks++;
    if (tmo || out_valid !== 1'b1 || sum !== 16'h0001 || carry_flag !== 1'b1)
      $display("FAIL carry_wrap: got ov=%b %h/%b want 1 0001/1", out_valid, sum, carry_flag);
    else n_pass++;
    take_result(1);
    ops[0] = 16'h0005;
    pulse_start(1);
    feed_ops(1, 0, early, tmo);
    n_checks++;
    if (tmo || out_valid !== 1'b1 || sum !== 16'h0005 || carry_flag !== 1'b0)
      $display("FAIL carry_cleared: got ov=%b %h/%b want 1 0005/0", out_valid, sum, carry_flag);
    else n_pass++;
    take_result(0);
  endtask

  task automatic test_zero_len();
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL zero_idle_ready: got %b want 0", in_ready);
    else n_pass++;
    pulse_start(0);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0 || carry_flag !== 1'b0)
      $display("FAIL zero_len: got ov=%b ir=%b %h/%b want 1 0 0000/0",
               out_valid, in_ready, sum, carry_flag);
    else n_pass++;
    take_result(0);
  endtask

  task automatic test_gaps();
    bit vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit early = 1'b0;
    int acc = 0;
    pulse_start(4);
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i];
      in_data  = 16'h1000;
      tick();
      if (vpat[i]) acc++;
      if (acc < 4 && out_valid) early = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (early || out_valid !== 1'b1 || sum !== 16'h4000)
      $display("FAIL gaps_sum: got ov=%b early=%b sum=%h want 1 0 4000", out_valid, early, sum);
    else n_pass++;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd7;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h4000 || carry_flag !== 1'b0)
        $display("FAIL gaps_hold%0d: got ov=%b ir=%b %h/%b want 1 0 4000/0",
                 i, out_valid, in_ready, sum, carry_flag);
      else n_pass++;
    end
    // Start coinciding with the result handshake must be dropped.
    start     = 1'b1;
    len       = 8'd3;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL handshake_start_ignored: got busy=%b ov=%b ir=%b want 0 0 0",
               busy, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit early, tmo;
    pulse_start(5);
    in_valid = 1'b1;
    in_data  = 16'h0011;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, busy, carry_flag, sum} !== 20'h0)
      $display("FAIL reset_async: got ov=%b ir=%b busy=%b cf=%b sum=%h want all 0",
               out_valid, in_ready, busy, carry_flag, sum);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ops[0] = 16'h00AA;
    pulse_start(1);
    feed_ops(1, 0, early, tmo);
    n_checks++;
    if (tmo || out_valid !== 1'b1 || sum !== 16'h00AA || carry_flag !== 1'b0)
      $display("FAIL reset_recover: got ov=%b %h/%b want 1 00aa/0", out_valid, sum, carry_flag);
    else n_pass++;
    take_result(0);
  endtask

  task automatic test_random();
    bit          early, tmo;
    logic [15:0] exp_sum;
    logic        exp_flag;
    int          n;
    for (int b = 0; b < 20; b++) begin
      n = (b == 0) ? 255 : int'($urandom_range(255, 1));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(3))
          0:       ops[i] = 16'($urandom_range(255));
          1:       ops[i] = 16'($urandom_range(16'hFFFF, 16'hF000));
          default: ops[i] = 16'($urandom);
        endcase
      end
      model(n, exp_sum, exp_flag);
      pulse_start(n);
      feed_ops(n, int'($urandom_range(50)), early, tmo);
      n_checks++;
      if (early || tmo || out_valid !== 1'b1)
        $display("FAIL rand%0d_handshake: got ov=%b early=%b tmo=%b want 1 0 0",
                 b, out_valid, early, tmo);
      else n_pass++;
      n_checks++;
      if (sum !== exp_sum || carry_flag !== exp_flag)
        $display("FAIL rand%0d_result: got %h/%b want %h/%b", b, sum, carry_flag,
                 exp_sum, exp_flag);
      else n_pass++;
      take_result(int'($urandom_range(3)));
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL rand%0d_release: got ov=%b busy=%b want 0 0", b, out_valid, busy);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_zero_len();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
